keypad_scan_ctrl: RTL and testbench
===================================

KEYPAD_SCAN_CTRL -- requirements
Module: keypad_scan_ctrl

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 50000, giving clk cycles per row dwell and per debounce sample (1 ms at 50 MHz); legal values are 4 or more.
REQ-002 SHALL have parameter DEB_COUNT, default 10, giving the number of consecutive matching samples that confirm a press or release; legal values are 2 to 255.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port row, output, 4 bits: active-low one-cold drive to the keypad rows.
REQ-006 SHALL have port col, input, 4 bits: active-low keypad column returns, asynchronous to clk.
REQ-007 SHALL have port key_code, output, 4 bits: code of the most recent confirmed press.
REQ-008 SHALL have port key_valid, output, 1 bit: a press event is pending for the Nios PIO.
REQ-009 SHALL have port key_ack, input, 1 bit: single-cycle acknowledge from software.
REQ-010 SHALL have port key_down, output, 1 bit: high while a confirmed key is held.
REQ-011 SHALL have port key_overrun, output, 1 bit: sticky flag, set when an event is lost.
REQ-012 SHALL have port keyout, output, 5 bits: {key_down, key_code}, the legacy PIO view.

Function
REQ-013 SHALL pass col through a 2-FF synchronizer; all logic uses only the synchronized value colS.
REQ-014 SHALL rotate row in SCAN state through 1110, 1101, 1011, 0111, 1110, ..., holding each value for SCAN_DIV cycles.
REQ-015 SHALL take a sample of colS on the last cycle of each dwell; this is the only point at which colS is evaluated.
REQ-016 SHALL use code = row_idx*4 + col_idx, where row_idx is 0..3 for row 1110..0111 and col_idx is 0..3 for colS 1110..0111.
REQ-017 SHALL treat a sample with exactly one col bit low as a candidate and go SCAN->DEBOUNCE, freezing row and storing the candidate code; the detecting sample counts as match 1.
REQ-018 SHALL treat a sample with zero or with two or more col bits low as no key (ghost rejection); SCAN continues rotating.
REQ-019 SHALL, in DEBOUNCE, sample every SCAN_DIV cycles; a differing sample returns the FSM to SCAN, advancing to the next row.
REQ-020 SHALL, on the DEB_COUNT-th consecutive match, go to PRESSED, set key_down, load key_code and set key_valid, all on the following cycle.
REQ-021 SHALL, in PRESSED, keep row frozen and count consecutive all-high samples; any non-all-high sample resets the count.
REQ-022 SHALL, when the all-high count reaches DEB_COUNT, clear key_down and go PRESSED->SCAN, advancing to the next row.
REQ-023 SHALL clear key_valid on the cycle after key_ack is sampled high with key_valid high; key_ack while key_valid is low is ignored.
REQ-024 SHALL, when a new press is confirmed while key_valid=1 and no ack arrives that cycle, discard the new code, keep key_code unchanged and set key_overrun.
REQ-025 SHALL, when key_ack and a new confirmation occur in the same cycle, keep key_valid at 1, load the new code and leave key_overrun unchanged.
REQ-026 SHALL clear key_overrun only on an accepted key_ack that does not coincide with a new overrun.
REQ-027 SHALL size counters to the exact widths given by $clog2 of their parameters, with no wrap-around; the dwell counter reloads at SCAN_DIV-1.

Reset
REQ-028 SHALL, on reset_n low at any time, including mid-debounce, immediately force row=1110, state SCAN, counters to 0, key_code=0, key_valid=0, key_down=0, key_overrun=0 and the synchronizer to 1111.
REQ-029 SHALL, after reset release, make the first sample occur SCAN_DIV cycles later on row 1110.

Structure
REQ-030 SHALL place the FSM state encoding (SCAN, DEBOUNCE, PRESSED) and the default SCAN_DIV and DEB_COUNT values in the shared package keypad_pkg.
REQ-031 SHALL implement the 2-FF synchronizer as sub-module sync_2ff, 4 bits wide; all other logic stays in one module.

Verification
REQ-032 SHALL run with SCAN_DIV=4 and DEB_COUNT=3; the bench models the keypad by pulling col low for the pressed key only while its row is driven low.
REQ-033 Single press: hold key (row 1, col 2) for 40 cycles -> key_code=6, keyout=1_0110, key_valid rises on the cycle after the 3rd matching sample, and key_down falls 3 samples after release.
REQ-034 Bounce: key 0 is present for 1 sample, absent for 1, then stable -> no event from the first contact, then exactly one event with code 0.
REQ-035 Overrun: confirm key 5 with no ack, then confirm key 9 -> key_code stays 5 and key_overrun=1; a following ack clears both key_valid and key_overrun.
REQ-036 Same-cycle: key_ack coincides with confirmation of key 15 -> key_valid stays 1, key_code=15 and key_overrun=0.
REQ-037 Ghost: two keys on row 0 pressed together -> no event, and row keeps rotating through all four values.
REQ-038 Reset mid-operation: assert reset_n during DEBOUNCE -> row=1110 and all outputs 0 asynchronously, and no event after release until a new full debounce.

Source files
------------

// File: rtl/keypad_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | keypad_pkg                                                           |
// | Shared state encoding, default timing and column decode for keypad.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        PRESSED  = 2'd2
    } kp_state_t;

    localparam int c_scan_div_default  = 50000;
    localparam int c_deb_count_default = 10;

    // Returns {single_key, col_idx}; single_key is low for no key or ghosting.
    function automatic logic [2:0] col_decode(input logic [3:0] cols);
        case (cols)
            4'b1110: col_decode = 3'b100;
            4'b1101: col_decode = 3'b101;
            4'b1011: col_decode = 3'b110;
            4'b0111: col_decode = 3'b111;
            default: col_decode = 3'b000;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sync_2ff                                                             |
// | Two-flop synchronizer, resets to all ones (idle keypad columns).     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module sync_2ff #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_meta <= '1;
            r_sync <= '1;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule
`default_nettype wire

// File: rtl/keypad_scan_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | keypad_scan_ctrl                                                     |
// | 4x4 keypad row scanner with debounce, ghost rejection and PIO flags. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module keypad_scan_ctrl
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV  = c_scan_div_default,
    parameter int DEB_COUNT = c_deb_count_default
) (
    input  logic       clk,
    input  logic       reset_n,
    output logic [3:0] row,
    input  logic [3:0] col,
    output logic [3:0] key_code,
    output logic       key_valid,
    input  logic       key_ack,
    output logic       key_down,
    output logic       key_overrun,
    output logic [4:0] keyout
);

    localparam int c_div_w = $clog2(SCAN_DIV);
    localparam int c_deb_w = $clog2(DEB_COUNT);
    localparam logic [c_div_w-1:0] c_div_last = c_div_w'(SCAN_DIV - 1);
    localparam logic [c_deb_w-1:0] c_deb_last = c_deb_w'(DEB_COUNT - 1);
    localparam logic [c_deb_w-1:0] c_deb_one  = c_deb_w'(1);

    logic [3:0]         w_col_s;
    logic [2:0]         w_col_dec;
    logic               w_single;
    logic [1:0]         w_col_idx;
    logic               w_all_high;
    logic               w_tick;
    logic               w_ack_ok;

    kp_state_t          r_state;
    kp_state_t          w_state_nxt;
    logic [c_div_w-1:0] r_div_cnt;
    logic [c_deb_w-1:0] r_deb_cnt;
    logic [c_deb_w-1:0] w_deb_nxt;
    logic [1:0]         r_row_idx;
    logic [1:0]         r_cand_col;
    logic               w_row_adv;
    logic               w_cand_ld;
    logic               w_confirm;
    logic               w_release;

    logic [3:0]         r_key_code;
    logic               r_key_valid;
    logic               r_key_down;
    logic               r_key_overrun;

    sync_2ff #(.WIDTH(4)) u_col_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .i_d     (col),
        .o_q     (w_col_s)
    );

    assign w_col_dec  = col_decode(w_col_s);
    assign w_single   = w_col_dec[2];
    assign w_col_idx  = w_col_dec[1:0];
    assign w_all_high = (w_col_s == 4'b1111);
    assign w_tick     = (r_div_cnt == c_div_last);
    assign w_ack_ok   = key_ack & r_key_valid;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= SCAN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Columns are only evaluated on the last cycle of each dwell.
    always_comb begin
        w_state_nxt = r_state;
        w_deb_nxt   = r_deb_cnt;
        w_row_adv   = 1'b0;
        w_cand_ld   = 1'b0;
        w_confirm   = 1'b0;
        w_release   = 1'b0;
        if (w_tick) begin
            unique case (r_state)
                SCAN: begin
                    if (w_single) begin
                        w_state_nxt = DEBOUNCE;
                        w_deb_nxt   = c_deb_one;
                        w_cand_ld   = 1'b1;
                    end else begin
                        w_row_adv = 1'b1;
                    end
                end
                DEBOUNCE: begin
                    if (w_single && (w_col_idx == r_cand_col)) begin
                        if (r_deb_cnt == c_deb_last) begin
                            w_state_nxt = PRESSED;
                            w_deb_nxt   = '0;
                            w_confirm   = 1'b1;
                        end else begin
                            w_deb_nxt = r_deb_cnt + 1'b1;
                        end
                    end else begin
                        w_state_nxt = SCAN;
                        w_deb_nxt   = '0;
                        w_row_adv   = 1'b1;
                    end
                end
                PRESSED: begin
                    if (w_all_high) begin
                        if (r_deb_cnt == c_deb_last) begin
                            w_state_nxt = SCAN;
                            w_deb_nxt   = '0;
                            w_row_adv   = 1'b1;
                            w_release   = 1'b1;
                        end else begin
                            w_deb_nxt = r_deb_cnt + 1'b1;
                        end
                    end else begin
                        w_deb_nxt = '0;
                    end
                end
                default: begin
                    w_state_nxt = SCAN;
                    w_deb_nxt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_div_cnt     <= '0;
            r_deb_cnt     <= '0;
            r_row_idx     <= '0;
            r_cand_col    <= '0;
            r_key_code    <= '0;
            r_key_valid   <= 1'b0;
            r_key_down    <= 1'b0;
            r_key_overrun <= 1'b0;
        end else begin
            r_div_cnt <= w_tick ? '0 : r_div_cnt + 1'b1;
            r_deb_cnt <= w_deb_nxt;
            if (w_row_adv) r_row_idx <= r_row_idx + 2'd1;
            if (w_cand_ld) r_cand_col <= w_col_idx;

            if (w_confirm)      r_key_down <= 1'b1;
            else if (w_release) r_key_down <= 1'b0;

            // An unacknowledged pending event wins over a new press.
            if (w_confirm && r_key_valid && !key_ack) begin
                r_key_overrun <= 1'b1;
            end else if (w_confirm) begin
                r_key_code  <= {r_row_idx, r_cand_col};
                r_key_valid <= 1'b1;
            end else if (w_ack_ok) begin
                r_key_valid   <= 1'b0;
                r_key_overrun <= 1'b0;
            end
        end
    end

    assign row         = ~(4'b0001 << r_row_idx);
    assign key_code    = r_key_code;
    assign key_valid   = r_key_valid;
    assign key_down    = r_key_down;
    assign key_overrun = r_key_overrun;
    assign keyout      = {r_key_down, r_key_code};

endmodule
`default_nettype wire

// File: tb/tb_keypad_scan_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_keypad_scan_ctrl                                                  |
// | Directed scoreboard bench with a behavioural 4x4 keypad matrix.      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_keypad_scan_ctrl;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       key_ack;
    logic [3:0] row;
    logic [3:0] col;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_down;
    logic       key_overrun;
    logic [4:0] keyout;
    logic [15:0] keys;

    int n_checks = 0;
    int n_errors = 0;
    logic [4:0] exp_q[$];

    logic       mon_pv;
    logic [3:0] mon_pc;
    logic [4:0] mon_e;

    always #5 clk = ~clk;

    keypad_scan_ctrl #(
        .SCAN_DIV  (4),
        .DEB_COUNT (3)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .row         (row),
        .col         (col),
        .key_code    (key_code),
        .key_valid   (key_valid),
        .key_ack     (key_ack),
        .key_down    (key_down),
        .key_overrun (key_overrun),
        .keyout      (keyout)
    );

    // A held key pulls its column low only while its row is driven low.
    always_comb begin
        col = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && !row[r]) col[c] = 1'b0;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic wait_row(input logic [3:0] val);
        int n = 0;
        while (row == val && n < 64) begin @(negedge clk); n++; end
        while (row != val && n < 64) begin @(negedge clk); n++; end
        check("wait_row", 32'(row), 32'(val));
    endtask

    task automatic wait_down(input logic val);
        int n = 0;
        do begin @(negedge clk); n++; end while (key_down != val && n < 200);
        check("wait_key_down", 32'(key_down), 32'(val));
    endtask

    task automatic ack_pulse();
        @(posedge clk); #1 key_ack = 1'b1;
        @(posedge clk); #1 key_ack = 1'b0;
    endtask

    // Monitor: a new event is a rising key_valid or a code change while valid.
    initial begin
        mon_pv = 1'b0;
        mon_pc = 4'h0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                mon_pv = 1'b0;
            end else begin
                if (key_valid && (!mon_pv || key_code != mon_pc)) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL unexpected_event: code %0d keyout %b, none expected", key_code, keyout);
                    end else begin
                        mon_e = exp_q.pop_front();
                        check("event_code", 32'(key_code), 32'(mon_e[3:0]));
                        check("event_keyout", 32'(keyout), 32'(mon_e));
                    end
                end
                mon_pv = key_valid;
                mon_pc = key_code;
            end
        end
    end

    initial begin
        int run;
        int n;
        logic bad;
        logic [3:0] seen;
        logic [3:0] rot [4];

        reset_n = 1'b0;
        key_ack = 1'b0;
        keys    = 16'h0000;
        rot[0] = 4'b1011; rot[1] = 4'b0111; rot[2] = 4'b1110; rot[3] = 4'b1101;

        // Reset state and scan timing after release
        repeat (2) @(negedge clk);
        check("rst_row", 32'(row), 'hE);
        check("rst_key_code", 32'(key_code), 0);
        check("rst_key_valid", 32'(key_valid), 0);
        check("rst_key_down", 32'(key_down), 0);
        check("rst_key_overrun", 32'(key_overrun), 0);
        check("rst_keyout", 32'(keyout), 0);
        @(posedge clk); #1 reset_n = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk) check("first_dwell_row0", 32'(row), 'hE);
        @(posedge clk);
        @(negedge clk) check("first_dwell_row1", 32'(row), 'hD);
        for (int i = 0; i < 4; i++) begin
            repeat (4) @(posedge clk);
            @(negedge clk) check("rotate_row", 32'(row), 32'(rot[i]));
        end

        // Single press of key 6 (row 1, col 2)
        wait_row(4'b1110);
        exp_q.push_back(5'b10110);
        keys = 16'h0040;
        run = 0;
        n = 0;
        while (!key_valid && n < 100) begin
            @(negedge clk);
            n++;
            if (!key_valid) run = (row == 4'b1101) ? run + 1 : 0;
        end
        check("press_latency_cycles", 32'(run), 12);
        check("press_keyout", 32'(keyout), 'b10110);
        ack_pulse();
        @(negedge clk) check("ack_clears_valid", 32'(key_valid), 0);
        repeat (24) @(posedge clk);
        #1 keys = 16'h0000;
        n = 0;
        do begin @(posedge clk); n++; @(negedge clk); end while (key_down && n < 40);
        check("release_cycles", 32'(n), 14);
        check("release_row_advance", 32'(row), 'hB);

        // Bounce on key 0: one sample present, one absent, then stable
        wait_row(4'b1110);
        exp_q.push_back(5'b10000);
        keys = 16'h0001;
        repeat (4) @(posedge clk);
        #1 keys = 16'h0000;
        repeat (3) @(posedge clk);
        @(negedge clk) check("bounce_row_frozen", 32'(row), 'hE);
        @(posedge clk);
        @(negedge clk) check("bounce_row_advance", 32'(row), 'hD);
        keys = 16'h0001;
        wait_down(1'b1);
        ack_pulse();
        keys = 16'h0000;
        wait_down(1'b0);

        // Overrun: key 5 pending, then key 9 confirmed without ack
        exp_q.push_back(5'b10101);
        keys = 16'h0020;
        wait_down(1'b1);
        keys = 16'h0000;
        wait_down(1'b0);
        keys = 16'h0200;
        wait_down(1'b1);
        check("overrun_code_kept", 32'(key_code), 5);
        check("overrun_flag", 32'(key_overrun), 1);
        check("overrun_valid", 32'(key_valid), 1);
        ack_pulse();
        @(negedge clk);
        check("overrun_ack_valid", 32'(key_valid), 0);
        check("overrun_ack_flag", 32'(key_overrun), 0);
        keys = 16'h0000;
        wait_down(1'b0);

        // Ack coinciding with confirmation of key 15
        exp_q.push_back(5'b11100);
        keys = 16'h1000;
        wait_down(1'b1);
        keys = 16'h0000;
        wait_down(1'b0);
        exp_q.push_back(5'b11111);
        keys = 16'h8000;
        wait_row(4'b0111);
        repeat (11) @(posedge clk);
        #1 key_ack = 1'b1;
        @(posedge clk);
        #1 key_ack = 1'b0;
        @(negedge clk);
        check("same_cycle_valid", 32'(key_valid), 1);
        check("same_cycle_code", 32'(key_code), 15);
        check("same_cycle_overrun", 32'(key_overrun), 0);
        ack_pulse();
        keys = 16'h0000;
        wait_down(1'b0);

        // Ghost: keys 0 and 1 together on row 0
        keys = 16'h0003;
        seen = 4'h0;
        bad  = 1'b0;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            seen = seen | ~row;
            if (key_valid || key_down) bad = 1'b1;
        end
        check("ghost_rows_seen", 32'(seen), 'hF);
        check("ghost_no_event", 32'(bad), 0);
        keys = 16'h0000;

        // Reset asserted during debounce of key 4
        wait_row(4'b1110);
        keys = 16'h0010;
        wait_row(4'b1101);
        repeat (6) @(posedge clk);
        #1 reset_n = 1'b0;
        #1;
        check("async_rst_row", 32'(row), 'hE);
        check("async_rst_code", 32'(key_code), 0);
        check("async_rst_valid", 32'(key_valid), 0);
        check("async_rst_keyout", 32'(keyout), 0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        exp_q.push_back(5'b10100);
        bad = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (key_valid) bad = 1'b1;
        end
        check("post_rst_no_early_event", 32'(bad), 0);
        @(posedge clk);
        @(negedge clk) check("post_rst_full_debounce", 32'(key_valid), 1);
        ack_pulse();
        keys = 16'h0000;
        wait_down(1'b0);

        repeat (5) @(negedge clk);
        check("events_outstanding", 32'(exp_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
